base_sys_pio_gen: RTL and testbench
===================================

# base_sys_pio_gen

Parametrised general-purpose I/O port for the base_sys Avalon-MM peripheral set, successor to the fixed 8-bit output-only PIO. Provides per-bit direction control, atomic bit set/clear, synchronised input sampling, edge capture and a maskable level interrupt. Sits on the system interconnect as a zero-wait-state slave and drives board pins through out_port/oe_port.

## Interface

- WIDTH, 8, number of I/O bits, 1..32
- OUT_RESET, 0, reset value of the output data register (WIDTH bits)
- DIR_RESET, 0, reset value of the direction register (1 = output)
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge
- SYNC_STAGES, 2, input synchroniser depth, 2..3

- clk  in  1  system clock; the block has one clock
- reset  in  1  reset is asynchronous and active-high
- address  in  3  word register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; read when chipselect & write_n
- writedata  in  32  write data; bits above WIDTH ignored
- readdata  out  32  read data, zero-extended above WIDTH
- in_port  in  WIDTH  asynchronous pin inputs
- out_port  out  WIDTH  output data register
- oe_port  out  WIDTH  per-bit output enable (= direction register)
- irq  out  1  level interrupt

## Operation

- Register map (word address): 0 DATA, 1 DIR, 2 IRQ_MASK, 3 EDGE_CAP, 4 OUT_SET, 5 OUT_CLR, 6-7 reserved.
- Write strobe: chipselect & ~write_n, sampled at rising clk.
- DATA write: out_reg <= writedata. DATA read: bit i = dir[i] ? out_reg[i] : in_sync[i].
- DIR read/write: direction register. IRQ_MASK read/write: mask register.
- EDGE_CAP read: capture register. Write: bits written 1 are cleared, 0 untouched.
- OUT_SET write: out_reg <= out_reg | wd. OUT_CLR write: out_reg <= out_reg & ~wd. Both read as 0.
- Reserved addresses: writes ignored, reads 0.
- in_sync: SYNC_STAGES-deep flop chain per bit; in_prev = in_sync delayed one cycle.
- Edge detect per bit: rising = in_sync & ~in_prev; falling = ~in_sync & in_prev; any = in_sync ^ in_prev. Detection applies to every bit regardless of DIR.
- Capture: cap[i] <= 1 on detected edge; sticky until cleared by EDGE_CAP write. Edge and clear on same bit in same cycle: capture wins (bit stays 1).
- irq = |(cap & mask), combinational from registers (glitch-free).
- Reset (asynchronous, any time): out_reg = OUT_RESET, dir = DIR_RESET, mask = 0, cap = 0, synchroniser and in_prev = 0. Consequently out_port = OUT_RESET, oe_port = DIR_RESET, irq = 0. Reset mid-write discards the write.
- First edge after reset deassertion: in_prev starts at 0, so a pin held high through reset produces one rising capture at release; software clears EDGE_CAP after setup.

## Timing

- Zero wait states; readdata combinational from address and registers, valid in the same cycle as the read.
- Writes visible on out_port/oe_port and in readback the cycle after the write edge.
- Input latency (SYNC_STAGES = 2): in_port stable before edge k; in_sync updated at k+1 (DATA readback reflects it then); cap set at edge k+2; irq asserted after k+2 if masked in.
- Clearing cap or mask deasserts irq the cycle after the write edge.
- Pulses on in_port shorter than one clk period may be missed; no guarantee.

## Test plan

- Reset with OUT_RESET=8'hA5, DIR_RESET=8'h0F -> out_port=A5, oe_port=0F, irq=0, all readbacks match; assert reset mid-write of DATA=FF -> out_port stays A5.
- Write DATA=3C, OUT_SET=01, OUT_CLR=0C -> out_port 3C, 3D, 31 on successive cycles; reads of 4/5/6/7 return 0.
- DIR=F0, out_reg=AA, in_port=05 -> DATA read returns A5 after 2 cycles.
- EDGE_TYPE=0, mask=01, bit0 0->1 before edge k -> cap=01 and irq=1 after edge k+2; falling edge leaves cap unchanged; EDGE_TYPE=2 captures both.
- EDGE_CAP write 01 in the same cycle as a new bit0 edge -> cap stays 01, irq stays 1; later write 01 with no edge -> cap=00, irq=0 next cycle.
- WIDTH=32 build: write FFFFFFFF to DATA, DIR -> readback FFFFFFFF; WIDTH=5 build -> readdata[31:5]=0.

Source files
------------

// File: rtl/base_sys_pio_gen.sv
// rtl/base_sys_pio_gen.sv - parametrised Avalon-MM GPIO with direction, set/clear, edge capture and irq
module base_sys_pio_gen #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    localparam logic [2:0] A_DATA = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_MASK = 3'd2;
    localparam logic [2:0] A_CAP  = 3'd3;
    localparam logic [2:0] A_SET  = 3'd4;
    localparam logic [2:0] A_CLR  = 3'd5;

    logic [WIDTH-1:0] out_reg, dir_reg, mask_reg, cap_reg;
    logic [WIDTH-1:0] in_sync, in_prev, edge_det, cap_clr, wd;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic             wr_en;
    logic             unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign in_sync   = sync_q[SYNC_STAGES-1];
    assign cap_clr   = (wr_en && address == A_CAP) ? wd : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            in_prev <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            in_prev <= in_sync;
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_det = in_sync & ~in_prev;
            1:       edge_det = ~in_sync & in_prev;
            default: edge_det = in_sync ^ in_prev;
        endcase
    end

    // A fresh edge overrides a simultaneous software clear so no event is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_reg  <= OUT_RESET;
            dir_reg  <= DIR_RESET;
            mask_reg <= '0;
            cap_reg  <= '0;
        end else begin
            cap_reg <= (cap_reg & ~cap_clr) | edge_det;
            if (wr_en) begin
                case (address)
                    A_DATA:  out_reg  <= wd;
                    A_DIR:   dir_reg  <= wd;
                    A_MASK:  mask_reg <= wd;
                    A_SET:   out_reg  <= out_reg | wd;
                    A_CLR:   out_reg  <= out_reg & ~wd;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            A_DATA:  readdata[WIDTH-1:0] = (dir_reg & out_reg) | (~dir_reg & in_sync);
            A_DIR:   readdata[WIDTH-1:0] = dir_reg;
            A_MASK:  readdata[WIDTH-1:0] = mask_reg;
            A_CAP:   readdata[WIDTH-1:0] = cap_reg;
            default: ;
        endcase
    end

    assign out_port = out_reg;
    assign oe_port  = dir_reg;
    assign irq      = |(cap_reg & mask_reg);

endmodule

// File: tb/tb_base_sys_pio_gen.sv
// tb/tb_base_sys_pio_gen.sv - randomized self-checking bench for base_sys_pio_gen against a delay-line model
module tb_base_sys_pio_gen;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata, pins;

    logic [31:0] rd [N];
    logic        irq_obs [N];
    logic [7:0]  o0, e0, o1, e1;
    logic [4:0]  o2, e2;
    logic [31:0] o3, e3;
    logic [31:0] out_obs [N];
    logic [31:0] oe_obs [N];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wmask [N];
    int          etype [N];
    logic [31:0] out_rst [N];
    logic [31:0] dir_rst [N];
    logic [31:0] m_out [N], m_dir [N], m_mask [N], m_cap [N];
    logic [31:0] hist [3];

    always #5 clk = ~clk;

    base_sys_pio_gen #(.WIDTH(8), .OUT_RESET(8'hA5), .DIR_RESET(8'h0F), .EDGE_TYPE(0)) u_r8 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd[0]), .in_port(pins[7:0]),
        .out_port(o0), .oe_port(e0), .irq(irq_obs[0]));
    base_sys_pio_gen #(.WIDTH(8), .OUT_RESET(8'h5A), .DIR_RESET(8'hF0), .EDGE_TYPE(2)) u_a8 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd[1]), .in_port(pins[7:0]),
        .out_port(o1), .oe_port(e1), .irq(irq_obs[1]));
    base_sys_pio_gen #(.WIDTH(5), .OUT_RESET(5'h15), .DIR_RESET(5'h0A), .EDGE_TYPE(1)) u_f5 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd[2]), .in_port(pins[4:0]),
        .out_port(o2), .oe_port(e2), .irq(irq_obs[2]));
    base_sys_pio_gen #(.WIDTH(32), .OUT_RESET(32'hDEADBEEF), .DIR_RESET(32'h0000FFFF), .EDGE_TYPE(2)) u_a32 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd[3]), .in_port(pins),
        .out_port(o3), .oe_port(e3), .irq(irq_obs[3]));

    assign out_obs[0] = {24'b0, o0};
    assign out_obs[1] = {24'b0, o1};
    assign out_obs[2] = {27'b0, o2};
    assign out_obs[3] = o3;
    assign oe_obs[0]  = {24'b0, e0};
    assign oe_obs[1]  = {24'b0, e1};
    assign oe_obs[2]  = {27'b0, e2};
    assign oe_obs[3]  = e3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_out[i]  = out_rst[i];
            m_dir[i]  = dir_rst[i];
            m_mask[i] = 32'h0;
            m_cap[i]  = 32'h0;
        end
        for (int j = 0; j < 3; j++) hist[j] = 32'h0;
    endfunction

    // hist[0] = first sync stage, hist[1] = synchronised pin value, hist[2] = its previous value
    function automatic void model_edge();
        logic [31:0] det, clr, wd;
        bit          wr;
        wr = chipselect && !write_n;
        for (int i = 0; i < N; i++) begin
            wd = writedata & wmask[i];
            case (etype[i])
                0:       det = hist[1] & ~hist[2];
                1:       det = ~hist[1] & hist[2];
                default: det = hist[1] ^ hist[2];
            endcase
            clr = (wr && address == 3'd3) ? wd : 32'h0;
            m_cap[i] = ((m_cap[i] & ~clr) | det) & wmask[i];
            if (wr) begin
                case (address)
                    3'd0: m_out[i] = wd;
                    3'd1: m_dir[i] = wd;
                    3'd2: m_mask[i] = wd;
                    3'd4: m_out[i] = m_out[i] | wd;
                    3'd5: m_out[i] = m_out[i] & ~wd;
                    default: ;
                endcase
            end
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = pins;
    endfunction

    function automatic logic [31:0] model_read(input int i, input logic [2:0] a);
        case (a)
            3'd0:    return ((m_dir[i] & m_out[i]) | (~m_dir[i] & hist[1])) & wmask[i];
            3'd1:    return m_dir[i];
            3'd2:    return m_mask[i];
            3'd3:    return m_cap[i];
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_outputs(input string ph);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_out%0d", ph, i), out_obs[i], m_out[i]);
            check($sformatf("%s_oe%0d", ph, i), oe_obs[i], m_dir[i]);
            check($sformatf("%s_irq%0d", ph, i), {31'b0, irq_obs[i]}, {31'b0, |(m_cap[i] & m_mask[i])});
        end
    endtask

    task automatic check_read(input string ph);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_rd%0d_a%0d", ph, i, address), rd[i], model_read(i, address));
        end
    endtask

    task automatic do_cycle(input logic [2:0] a, input logic cs, input logic wn,
                            input logic [31:0] wd, input logic [31:0] p);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        pins       = p;
        #1;
        if (cs && wn) check_read("cyc");
        @(posedge clk);
        model_edge();
        #1;
        check_outputs("cyc");
    endtask

    task automatic pulse_reset(input bit across_edge);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("rst");
        if (across_edge) begin
            @(posedge clk);
            #1;
            check_outputs("rsth");
        end
        reset = 1'b0;
    endtask

    initial begin
        wmask   = '{32'hFF, 32'hFF, 32'h1F, 32'hFFFFFFFF};
        etype   = '{0, 2, 1, 2};
        out_rst = '{32'hA5, 32'h5A, 32'h15, 32'hDEADBEEF};
        dir_rst = '{32'h0F, 32'hF0, 32'h0A, 32'h0000FFFF};
        reset = 1'b1;
        address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0; pins = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("init");
        check("init_out_const", out_obs[0], 32'hA5);
        check("init_oe_const", oe_obs[0], 32'h0F);
        for (int a = 0; a < 8; a++) begin
            address = 3'(a); chipselect = 1'b1; write_n = 1'b1;
            #1;
            check_read("init");
        end
        reset = 1'b0;
        chipselect = 1'b0;
        @(posedge clk);
        #1;

        // reset asserted while a DATA write is on the bus
        address = 3'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 32'hFF;
        pulse_reset(1'b1);
        check("midwr_out", out_obs[0], 32'hA5);
        do_cycle(3'd7, 1'b0, 1'b1, 32'h0, 32'h0);

        do_cycle(3'd0, 1'b1, 1'b0, 32'h3C, 32'h0);
        check("data_wr", out_obs[0], 32'h3C);
        do_cycle(3'd4, 1'b1, 1'b0, 32'h01, 32'h0);
        check("set_wr", out_obs[0], 32'h3D);
        do_cycle(3'd5, 1'b1, 1'b0, 32'h0C, 32'h0);
        check("clr_wr", out_obs[0], 32'h31);
        for (int a = 4; a < 8; a++) do_cycle(3'(a), 1'b1, 1'b1, 32'h0, 32'h0);

        do_cycle(3'd1, 1'b1, 1'b0, 32'hF0, 32'h0);
        do_cycle(3'd0, 1'b1, 1'b0, 32'hAA, 32'h0);
        do_cycle(3'd7, 1'b0, 1'b1, 32'h0, 32'h05);
        do_cycle(3'd7, 1'b0, 1'b1, 32'h0, 32'h05);
        do_cycle(3'd0, 1'b1, 1'b1, 32'h0, 32'h05);
        check("mixed_rd", rd[0], 32'hA5);
        do_cycle(3'd3, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h05);
        do_cycle(3'd3, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h05);

        do_cycle(3'd2, 1'b1, 1'b0, 32'h1, 32'h05);
        repeat (3) do_cycle(3'd7, 1'b0, 1'b1, 32'h0, 32'h04);
        do_cycle(3'd3, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h04);
        do_cycle(3'd7, 1'b0, 1'b1, 32'h0, 32'h05);
        do_cycle(3'd7, 1'b0, 1'b1, 32'h0, 32'h05);
        check("irq_early", {31'b0, irq_obs[0]}, 32'h0);
        do_cycle(3'd7, 1'b0, 1'b1, 32'h0, 32'h05);
        check("irq_rise", {31'b0, irq_obs[0]}, 32'h1);
        do_cycle(3'd3, 1'b1, 1'b1, 32'h0, 32'h05);
        check("cap_rise", rd[0], 32'h01);
        do_cycle(3'd3, 1'b1, 1'b0, 32'h1, 32'h05);
        check("irq_clr", {31'b0, irq_obs[0]}, 32'h0);
        repeat (3) do_cycle(3'd7, 1'b0, 1'b1, 32'h0, 32'h04);
        do_cycle(3'd3, 1'b1, 1'b1, 32'h0, 32'h04);
        check("cap_fall_rise", rd[0], 32'h00);
        check("cap_fall_any", rd[1] & 32'h1, 32'h1);
        do_cycle(3'd7, 1'b0, 1'b1, 32'h0, 32'h05);
        do_cycle(3'd7, 1'b0, 1'b1, 32'h0, 32'h05);
        do_cycle(3'd3, 1'b1, 1'b0, 32'h1, 32'h05);
        check("race_irq", {31'b0, irq_obs[0]}, 32'h1);
        do_cycle(3'd3, 1'b1, 1'b1, 32'h0, 32'h05);
        check("race_cap", rd[0], 32'h01);
        do_cycle(3'd3, 1'b1, 1'b0, 32'h1, 32'h05);
        check("late_irq", {31'b0, irq_obs[0]}, 32'h0);
        do_cycle(3'd3, 1'b1, 1'b1, 32'h0, 32'h05);
        check("late_cap", rd[0], 32'h00);

        do_cycle(3'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h05);
        do_cycle(3'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h05);
        do_cycle(3'd0, 1'b1, 1'b1, 32'h0, 32'h05);
        check("w32_rd", rd[3], 32'hFFFFFFFF);
        check("w5_rd", rd[2], 32'h1F);

        for (int n = 0; n < 800; n++) begin
            logic [31:0] p;
            p = pins;
            if ($urandom_range(0, 3) == 0) p = $urandom;
            if ($urandom_range(0, 63) == 0) pulse_reset(1'($urandom_range(0, 1)));
            do_cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom, p);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
